// File: rtl/ibex_pkg.sv
// Shared types for the Ibex custom-instruction execution unit (ibex_cust_unit).
package ibex_pkg;

  typedef enum logic [1:0] {
    CUST_ROTR = 2'd0,
    CUST_ROTL = 2'd1,
    CUST_CPOP = 2'd2,
    CUST_CLZ  = 2'd3
  } cust_op_e;

  typedef enum logic [1:0] {
    CUST_IDLE = 2'd0,
    CUST_BUSY = 2'd1,
    CUST_DONE = 2'd2
  } cust_state_e;

  // One conditional power-of-two rotate stage per amount bit.
  function automatic int unsigned CUST_ROT_STEPS(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/ibex_cust_chunk_cnt.sv
// Combinational popcount and leading-zero count of one ChunkW-bit slice.
module ibex_cust_chunk_cnt #(
  parameter int unsigned ChunkW = 8
) (
  input  logic [ChunkW-1:0]        chunk_i,
  output logic [$clog2(ChunkW):0]  popcnt_o,
  output logic [$clog2(ChunkW):0]  lzc_o,
  output logic                     any_one_o
);

  localparam int unsigned CntW = $clog2(ChunkW) + 1;

  logic found;

  // MSB-first scan: zeros count toward lzc only until the first one.
  always_comb begin
    popcnt_o = '0;
    lzc_o    = '0;
    found    = 1'b0;
    for (int i = ChunkW - 1; i >= 0; i--) begin
      popcnt_o = popcnt_o + CntW'(chunk_i[i]);
      if (chunk_i[i]) begin
        found = 1'b1;
      end else if (!found) begin
        lzc_o = lzc_o + CntW'(1);
      end
    end
  end

  assign any_one_o = |chunk_i;

endmodule

// File: rtl/ibex_cust_unit.sv
// Iterative custom-op unit: rotate right/left and, with IBEX_CUST_CNT_EN defined,
// popcount / count-leading-zeros. Without the macro count ops retire as illegal.
module ibex_cust_unit
  import ibex_pkg::*;
#(
  parameter int unsigned Width  = 32,
  parameter int unsigned ChunkW = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  cust_op_e         operator_i,
  input  logic [Width-1:0] operand_a_i,
  input  logic [Width-1:0] operand_b_i,
  input  logic             kill_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] result_o,
  output logic             illegal_o
);

  localparam int unsigned AmtW     = $clog2(Width);
  localparam int unsigned RotSteps = CUST_ROT_STEPS(Width);
  localparam int unsigned NChunks  = Width / ChunkW;
  localparam int unsigned StepW    = AmtW + 1;
  localparam int unsigned AccW     = AmtW + 1;

  cust_state_e      state_q, state_d;
  cust_op_e         op_q, op_d;
  logic [Width-1:0] work_q, work_d;
  logic [AmtW-1:0]  amt_q, amt_d;
  logic [StepW-1:0] step_q, step_d;
  logic             valid_q, valid_d;
  logic             illegal_q, illegal_d;
  logic [Width-1:0] result_q, result_d;

  logic             is_rot;
  logic             last_step;
  logic [AmtW:0]    sh_amt;
  logic [2*Width-1:0] dbl;
  logic [Width-1:0] rot_step;
  logic             unused_b;

  assign unused_b = ^operand_b_i[Width-1:AmtW];

`ifdef IBEX_CUST_CNT_EN
  logic [AccW-1:0]          acc_q, acc_d;
  logic                     seen_q, seen_d;
  logic [ChunkW-1:0]        chunk;
  logic [$clog2(ChunkW):0]  chunk_pop;
  logic [$clog2(ChunkW):0]  chunk_lzc;
  logic                     chunk_any;

  // CLZ walks chunks from the top, CPOP from the bottom.
  assign chunk = (op_q == CUST_CLZ) ? work_q[Width-1 -: ChunkW] : work_q[ChunkW-1:0];

  ibex_cust_chunk_cnt #(
    .ChunkW (ChunkW)
  ) u_chunk_cnt (
    .chunk_i   (chunk),
    .popcnt_o  (chunk_pop),
    .lzc_o     (chunk_lzc),
    .any_one_o (chunk_any)
  );
`endif

  // Rotate stage k: rotate right by 2^k when the current amount LSB is set.
  always_comb begin
    is_rot    = (op_q == CUST_ROTR) || (op_q == CUST_ROTL);
    last_step = is_rot ? (step_q == StepW'(RotSteps - 1)) : (step_q == StepW'(NChunks - 1));
    sh_amt    = (AmtW + 1)'(1) << step_q;
    dbl       = {work_q, work_q} >> sh_amt;
    rot_step  = amt_q[0] ? dbl[Width-1:0] : work_q;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    work_d    = work_q;
    amt_d     = amt_q;
    step_d    = step_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    result_d  = result_q;
`ifdef IBEX_CUST_CNT_EN
    acc_d     = acc_q;
    seen_d    = seen_q;
`endif

    unique case (state_q)
      CUST_IDLE: begin
        if (valid_i && !kill_i) begin
          op_d   = operator_i;
          work_d = operand_a_i;
          amt_d  = (operator_i == CUST_ROTL) ? AmtW'(AmtW'(0) - operand_b_i[AmtW-1:0])
                                             : operand_b_i[AmtW-1:0];
          step_d = '0;
`ifdef IBEX_CUST_CNT_EN
          acc_d   = '0;
          seen_d  = 1'b0;
          state_d = CUST_BUSY;
`else
          if ((operator_i == CUST_CPOP) || (operator_i == CUST_CLZ)) begin
            state_d   = CUST_DONE;
            valid_d   = 1'b1;
            illegal_d = 1'b1;
            result_d  = '0;
          end else begin
            state_d = CUST_BUSY;
          end
`endif
        end
      end

      CUST_BUSY: begin
        step_d = step_q + StepW'(1);
        if (is_rot) begin
          work_d = rot_step;
          amt_d  = amt_q >> 1;
        end
`ifdef IBEX_CUST_CNT_EN
        else if (op_q == CUST_CPOP) begin
          work_d = work_q >> ChunkW;
          acc_d  = acc_q + AccW'(chunk_pop);
        end else begin
          work_d = work_q << ChunkW;
          if (!seen_q) acc_d = acc_q + AccW'(chunk_lzc);
          seen_d = seen_q | chunk_any;
        end
`endif
        if (last_step) begin
          state_d   = CUST_DONE;
          valid_d   = 1'b1;
          illegal_d = 1'b0;
`ifdef IBEX_CUST_CNT_EN
          result_d  = is_rot ? rot_step : Width'(acc_d);
`else
          result_d  = rot_step;
`endif
        end
      end

      CUST_DONE: begin
        if (ready_i) begin
          state_d   = CUST_IDLE;
          valid_d   = 1'b0;
          illegal_d = 1'b0;
          result_d  = '0;
        end
      end

      default: state_d = CUST_IDLE;
    endcase

    // Flush overrides everything, including a same-cycle request.
    if (kill_i) begin
      state_d   = CUST_IDLE;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
      result_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CUST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q      <= CUST_ROTR;
      work_q    <= '0;
      amt_q     <= '0;
      step_q    <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      result_q  <= '0;
`ifdef IBEX_CUST_CNT_EN
      acc_q     <= '0;
      seen_q    <= 1'b0;
`endif
    end else begin
      op_q      <= op_d;
      work_q    <= work_d;
      amt_q     <= amt_d;
      step_q    <= step_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      result_q  <= result_d;
`ifdef IBEX_CUST_CNT_EN
      acc_q     <= acc_d;
      seen_q    <= seen_d;
`endif
    end
  end

  assign ready_o   = (state_q == CUST_IDLE);
  assign valid_o   = valid_q;
  assign result_o  = result_q;
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_ibex_cust_unit.sv
// Directed self-checking bench for ibex_cust_unit (32-bit and 64-bit instances);
// count-op expectations follow IBEX_CUST_CNT_EN.
module tb_ibex_cust_unit;
  import ibex_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        valid_i, ready_o, kill_i, valid_o, ready_i, illegal_o;
  cust_op_e    op_i;
  logic [31:0] a_i, b_i, result_o;

  logic        v64_i, rdy64_o, vo64_o, ri64_i, ill64_o;
  cust_op_e    op64_i;
  logic [63:0] a64_i, b64_i, res64_o;

  int n_tests = 0;
  int n_fail  = 0;

  ibex_cust_unit #(.Width(32), .ChunkW(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .operator_i(op_i), .operand_a_i(a_i), .operand_b_i(b_i), .kill_i(kill_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .illegal_o(illegal_o)
  );

  ibex_cust_unit #(.Width(64), .ChunkW(16)) dut64 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v64_i), .ready_o(rdy64_o),
    .operator_i(op64_i), .operand_a_i(a64_i), .operand_b_i(b64_i), .kill_i(1'b0),
    .valid_o(vo64_o), .ready_i(ri64_i), .result_o(res64_o), .illegal_o(ill64_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request, return cycles until valid_o (accept cycle = 0) and the result.
  task automatic issue(input cust_op_e op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output logic ill);
    valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result_o;
    ill = illegal_o;
  endtask

  task automatic consume(input string tag);
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk({tag, "_valid_cleared"}, 64'(valid_o), 64'd0);
    chk({tag, "_result_cleared"}, 64'(result_o), 64'd0);
  endtask

  int          lat;
  logic [31:0] res;
  logic        ill;
  int          lat64;
  logic        seen_valid;

  initial begin
    rst_n = 1'b0;
    valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b0; op_i = CUST_ROTR; a_i = '0; b_i = '0;
    v64_i = 1'b0; ri64_i = 1'b0; op64_i = CUST_ROTR; a64_i = '0; b64_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_result", 64'(result_o), 64'd0);
    chk("rst_illegal", 64'(illegal_o), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", 64'(ready_o), 64'd1);
    chk("idle_valid", 64'(valid_o), 64'd0);
    chk("idle64_ready", 64'(rdy64_o), 64'd1);

    // ROTR with back-pressure
    issue(CUST_ROTR, 32'h8000_0001, 32'd1, lat, res, ill);
    chk("rotr_lat", 64'(lat), 64'd6);
    chk("rotr_res", 64'(res), 64'hC000_0000);
    chk("rotr_ill", 64'(ill), 64'd0);
    chk("rotr_ready_busy", 64'(ready_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rotr_hold_valid", 64'(valid_o), 64'd1);
      chk("rotr_hold_res", 64'(result_o), 64'hC000_0000);
    end
    consume("rotr");
    chk("rotr_ready_after", 64'(ready_o), 64'd1);

    // ROTL, amount taken modulo Width, then amount 0
    issue(CUST_ROTL, 32'h1234_5678, 32'd36, lat, res, ill);
    chk("rotl4_lat", 64'(lat), 64'd6);
    chk("rotl4_res", 64'(res), 64'h2345_6781);
    consume("rotl4");
    issue(CUST_ROTL, 32'h1234_5678, 32'd0, lat, res, ill);
    chk("rotl0_lat", 64'(lat), 64'd6);
    chk("rotl0_res", 64'(res), 64'h1234_5678);
    consume("rotl0");
    issue(CUST_ROTR, 32'hF000_000F, 32'd7, lat, res, ill);
    chk("rotr7_res", 64'(res), 64'h1FE0_0000);
    consume("rotr7");

`ifdef IBEX_CUST_CNT_EN
    issue(CUST_CPOP, 32'hFFFF_0001, 32'hFFFF_FFFF, lat, res, ill);
    chk("cpop_lat", 64'(lat), 64'd5);
    chk("cpop_res", 64'(res), 64'd17);
    chk("cpop_ill", 64'(ill), 64'd0);
    consume("cpop");
    issue(CUST_CLZ, 32'h0000_0000, 32'd0, lat, res, ill);
    chk("clz0_lat", 64'(lat), 64'd5);
    chk("clz0_res", 64'(res), 64'd32);
    consume("clz0");
    issue(CUST_CLZ, 32'h0001_0000, 32'd0, lat, res, ill);
    chk("clz15_lat", 64'(lat), 64'd5);
    chk("clz15_res", 64'(res), 64'd15);
    consume("clz15");
    issue(CUST_CLZ, 32'h8000_0001, 32'd0, lat, res, ill);
    chk("clzmsb_lat", 64'(lat), 64'd5);
    chk("clzmsb_res", 64'(res), 64'd0);
    consume("clzmsb");
    op_i = CUST_CLZ;
`else
    issue(CUST_CPOP, 32'hFFFF_0001, 32'd0, lat, res, ill);
    chk("cpop_ill_lat", 64'(lat), 64'd1);
    chk("cpop_ill_flag", 64'(ill), 64'd1);
    chk("cpop_ill_res", 64'(res), 64'd0);
    consume("cpop_ill");
    chk("cpop_ill_cleared", 64'(illegal_o), 64'd0);
    issue(CUST_CLZ, 32'h0001_0000, 32'd0, lat, res, ill);
    chk("clz_ill_lat", 64'(lat), 64'd1);
    chk("clz_ill_flag", 64'(ill), 64'd1);
    consume("clz_ill");
    op_i = CUST_ROTR;
`endif

    // Kill during BUSY step 2
    valid_i = 1'b1; a_i = 32'h0001_0000; b_i = 32'd3;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    kill_i = 1'b1;
    @(posedge clk); #1;
    kill_i = 1'b0;
    chk("kill_ready", 64'(ready_o), 64'd1);
    chk("kill_valid", 64'(valid_o), 64'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      seen_valid |= valid_o;
    end
    chk("kill_no_valid", 64'(seen_valid), 64'd0);

    // Kill together with a request in IDLE
    valid_i = 1'b1; kill_i = 1'b1; op_i = CUST_ROTR; a_i = 32'h1; b_i = 32'h1;
    @(posedge clk); #1;
    valid_i = 1'b0; kill_i = 1'b0;
    chk("killreq_ready", 64'(ready_o), 64'd1);
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      seen_valid |= valid_o;
    end
    chk("killreq_no_valid", 64'(seen_valid), 64'd0);

    // Post-kill sanity
    issue(CUST_ROTR, 32'h0000_00FF, 32'd4, lat, res, ill);
    chk("rotr_post_kill_res", 64'(res), 64'hF000_000F);
    consume("rotr_post_kill");

    // 64-bit instance, ROTR
    v64_i = 1'b1; op64_i = CUST_ROTR; a64_i = 64'h8000_0000_0000_0001; b64_i = 64'd1;
    @(posedge clk); #1;
    v64_i = 1'b0;
    lat64 = 1;
    while (!vo64_o && lat64 < 20) begin
      @(posedge clk); #1;
      lat64++;
    end
    chk("rotr64_lat", 64'(lat64), 64'd7);
    chk("rotr64_res", res64_o, 64'hC000_0000_0000_0000);
    chk("rotr64_ill", 64'(ill64_o), 64'd0);
    ri64_i = 1'b1;
    @(posedge clk); #1;
    ri64_i = 1'b0;
    chk("rotr64_cleared", 64'(vo64_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
